// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data memory shared between a host port (IDLE) and a multi-lane processor port (RUN).
module data_mem_ctrl #(
  parameter int REG_WIDTH           = 12,
  parameter int CORE_COUNT          = 4,
  parameter int DATA_MEM_ADDR_WIDTH = 12
) (
  input  logic                                clk,
  input  logic                                rstN,
  input  logic                                host_start,
  input  logic                                host_wr_en,
  input  logic                                host_rd_en,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0]      host_addr,
  input  logic [REG_WIDTH*CORE_COUNT-1:0]     host_wdata,
  output logic [REG_WIDTH*CORE_COUNT-1:0]     host_rdata,
  output logic                                host_rvalid,
  output logic                                busy,
  output logic [15:0]                         run_cycles,
  output logic                                proc_start,
  input  logic                                proc_done,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0]      proc_addr,
  input  logic                                proc_wr_en,
  input  logic [REG_WIDTH*CORE_COUNT-1:0]     proc_wdata,
  output logic [REG_WIDTH*CORE_COUNT-1:0]     proc_rdata
);
  localparam int W     = REG_WIDTH * CORE_COUNT;
  localparam int DEPTH = 2 ** DATA_MEM_ADDR_WIDTH;
  typedef enum logic {IDLE, RUN} state_t;
  state_t                         state;
  logic [W-1:0]                   mem [DEPTH];
  logic                           run, mem_we;
  logic [DATA_MEM_ADDR_WIDTH-1:0] mem_wa;
  logic [W-1:0]                   mem_wd;
  assign run = state == RUN;
  // Single write port: ownership of the memory follows the FSM state.
  always_comb begin
    mem_we = run ? proc_wr_en : host_wr_en;
    mem_wa = run ? proc_addr : host_addr;
    mem_wd = run ? proc_wdata : host_wdata;
  end
  always_ff @(posedge clk)
    if (rstN && mem_we) mem[mem_wa] <= mem_wd;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= IDLE;
      busy        <= 1'b0;
      proc_start  <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      proc_rdata  <= '0;
      run_cycles  <= '0;
    end else begin
      proc_start  <= 1'b0;
      host_rvalid <= 1'b0;
      if (run) begin
        proc_rdata <= mem[proc_addr];
        run_cycles <= run_cycles == 16'hFFFF ? run_cycles : run_cycles + 16'd1;
        if (proc_done) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        if (host_rd_en && !host_wr_en) begin
          host_rdata  <= mem[host_addr];
          host_rvalid <= 1'b1;
        end
        if (host_start) begin
          state      <= RUN;
          busy       <= 1'b1;
          proc_start <= 1'b1;
          run_cycles <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl.
module tb_data_mem_ctrl;
  localparam int W = 48;
  localparam int A = 12;
  localparam logic [W-1:0] D5 = 48'h00A_00B_00C_00D;
  localparam logic [W-1:0] PX = 48'h111_222_333_444;
  localparam logic [W-1:0] PY = 48'h555_666_777_888;
  logic clk = 0, rstN = 1;
  logic host_start = 0, host_wr_en = 0, host_rd_en = 0, proc_done = 0, proc_wr_en = 0;
  logic [A-1:0] host_addr = '0, proc_addr = '0;
  logic [W-1:0] host_wdata = '0, proc_wdata = '0;
  logic [W-1:0] host_rdata, proc_rdata;
  logic host_rvalid, busy, proc_start;
  logic [15:0] run_cycles;
  int n_checks = 0, n_fail = 0;

  data_mem_ctrl dut (
    .clk(clk), .rstN(rstN), .host_start(host_start), .host_wr_en(host_wr_en),
    .host_rd_en(host_rd_en), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .busy(busy),
    .run_cycles(run_cycles), .proc_start(proc_start), .proc_done(proc_done),
    .proc_addr(proc_addr), .proc_wr_en(proc_wr_en), .proc_wdata(proc_wdata),
    .proc_rdata(proc_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rstN = 0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    n_checks++; if (host_rvalid !== 1'b0 || proc_start !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got rvalid=%0b start=%0b exp 0/0", host_rvalid, proc_start); end
    n_checks++; if (host_rdata !== '0 || proc_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h exp 0/0", host_rdata, proc_rdata); end
    n_checks++; if (run_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_cycles: got %0d exp 0", run_cycles); end
    step(); step();
    rstN = 1;
    step();
  endtask

  task automatic test_host_rw();
    host_wr_en = 1; host_addr = 5; host_wdata = D5;
    step();
    n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL host_wr_rvalid: got %0b exp 0", host_rvalid); end
    host_wr_en = 0; host_rd_en = 1;
    step();
    host_rd_en = 0;
    n_checks++; if (host_rvalid !== 1'b1 || host_rdata !== D5) begin n_fail++; $display("FAIL host_read5: got rvalid=%0b data=%h exp 1/%h", host_rvalid, host_rdata, D5); end
    step();
    n_checks++; if (host_rvalid !== 1'b0 || host_rdata !== D5) begin n_fail++; $display("FAIL host_rvalid_pulse: got rvalid=%0b data=%h exp 0/%h", host_rvalid, host_rdata, D5); end
  endtask

  task automatic test_run();
    host_start = 1;
    step();
    host_start = 0;
    n_checks++; if (busy !== 1'b1 || proc_start !== 1'b1 || run_cycles !== 16'd0) begin n_fail++; $display("FAIL run_entry: got busy=%0b start=%0b cyc=%0d exp 1/1/0", busy, proc_start, run_cycles); end
    step();
    n_checks++; if (proc_start !== 1'b0 || run_cycles !== 16'd1) begin n_fail++; $display("FAIL run_second: got start=%0b cyc=%0d exp 0/1", proc_start, run_cycles); end
    repeat (8) step();
    proc_done = 1;
    step();
    proc_done = 0;
    n_checks++; if (busy !== 1'b0 || run_cycles !== 16'd10) begin n_fail++; $display("FAIL run_done: got busy=%0b cyc=%0d exp 0/10", busy, run_cycles); end
    proc_done = 1;
    step(); step();
    proc_done = 0;
    n_checks++; if (busy !== 1'b0 || run_cycles !== 16'd10 || proc_start !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got busy=%0b cyc=%0d start=%0b exp 0/10/0", busy, run_cycles, proc_start); end
  endtask

  task automatic test_proc_rw();
    host_start = 1;
    step();
    host_start = 0;
    proc_wr_en = 1; proc_addr = 3; proc_wdata = PX;
    step();
    proc_wdata = PY;
    step();
    n_checks++; if (proc_rdata !== PX) begin n_fail++; $display("FAIL proc_rdw_old: got %h exp %h", proc_rdata, PX); end
    proc_wr_en = 0;
    step();
    n_checks++; if (proc_rdata !== PY) begin n_fail++; $display("FAIL proc_read: got %h exp %h", proc_rdata, PY); end
    proc_done = 1;
    step();
    proc_done = 0;
    proc_wr_en = 1; proc_wdata = 48'hDEAD_BEEF_0001;
    step();
    proc_wr_en = 0;
    n_checks++; if (proc_rdata !== PY) begin n_fail++; $display("FAIL proc_rdata_hold: got %h exp %h", proc_rdata, PY); end
    host_rd_en = 1; host_addr = 3;
    step();
    host_rd_en = 0;
    n_checks++; if (host_rvalid !== 1'b1 || host_rdata !== PY) begin n_fail++; $display("FAIL host_read3: got rvalid=%0b data=%h exp 1/%h", host_rvalid, host_rdata, PY); end
  endtask

  task automatic test_host_in_run();
    bit seen = 0;
    host_wr_en = 1; host_addr = 7; host_wdata = 48'h777;
    step();
    host_wr_en = 0; host_start = 1;
    step();
    host_start = 0;
    host_wr_en = 1; host_wdata = 48'hBAD;
    step();
    seen |= host_rvalid;
    host_wr_en = 0; host_rd_en = 1;
    step();
    seen |= host_rvalid;
    host_rd_en = 0;
    n_checks++; if (seen || host_rdata !== PY) begin n_fail++; $display("FAIL host_in_run: got rvalid_seen=%0b data=%h exp 0/%h", seen, host_rdata, PY); end
    proc_done = 1;
    step();
    proc_done = 0;
    host_rd_en = 1;
    step();
    host_rd_en = 0;
    n_checks++; if (host_rdata !== 48'h777) begin n_fail++; $display("FAIL mem7_kept: got %h exp 777", host_rdata); end
  endtask

  task automatic test_both_strobes();
    host_wr_en = 1; host_rd_en = 1; host_addr = 9; host_wdata = 48'hABC_DEF;
    step();
    host_wr_en = 0; host_rd_en = 0;
    n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL both_rvalid: got %0b exp 0", host_rvalid); end
    host_rd_en = 1;
    step();
    host_rd_en = 0;
    n_checks++; if (host_rdata !== 48'hABC_DEF) begin n_fail++; $display("FAIL both_write: got %h exp abcdef", host_rdata); end
  endtask

  task automatic test_start_with_access();
    host_start = 1; host_rd_en = 1; host_addr = 5;
    step();
    host_start = 0; host_rd_en = 0;
    n_checks++; if (busy !== 1'b1 || host_rvalid !== 1'b1 || host_rdata !== D5) begin n_fail++; $display("FAIL start_with_read: got busy=%0b rvalid=%0b data=%h exp 1/1/%h", busy, host_rvalid, host_rdata, D5); end
    repeat (70000) @(posedge clk);
    #1;
    n_checks++; if (run_cycles !== 16'hFFFF || busy !== 1'b1) begin n_fail++; $display("FAIL saturate: got cyc=%h busy=%0b exp ffff/1", run_cycles, busy); end
    proc_done = 1;
    step();
    proc_done = 0;
    n_checks++; if (busy !== 1'b0 || run_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_exit: got busy=%0b cyc=%h exp 0/ffff", busy, run_cycles); end
  endtask

  task automatic test_async_reset();
    host_start = 1;
    step();
    host_start = 0;
    step();
    proc_addr = 5; proc_wdata = 48'hFFF_FFF_FFF_FFF;
    step();
    proc_wr_en = 1;
    #3 rstN = 0;
    #1;
    n_checks++; if (busy !== 1'b0 || proc_start !== 1'b0 || run_cycles !== 16'd0 || proc_rdata !== '0 || host_rdata !== '0 || host_rvalid !== 1'b0) begin n_fail++; $display("FAIL async_reset: got busy=%0b cyc=%0d prd=%h hrd=%h exp all 0", busy, run_cycles, proc_rdata, host_rdata); end
    step();
    proc_wr_en = 0;
    rstN = 1;
    step();
    host_rd_en = 1; host_addr = 5;
    step();
    host_rd_en = 0;
    n_checks++; if (host_rvalid !== 1'b1 || host_rdata !== D5 || busy !== 1'b0) begin n_fail++; $display("FAIL mem_after_reset: got rvalid=%0b data=%h busy=%0b exp 1/%h/0", host_rvalid, host_rdata, busy, D5); end
  endtask

  initial begin
    test_reset();
    test_host_rw();
    test_run();
    test_proc_rw();
    test_host_in_run();
    test_both_strobes();
    test_start_with_access();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
